// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle core: instruction field widths,
// opcode map, control sub-ops, flag bit positions and FSM state encoding.
package mc_pkg;

  localparam int unsigned IW   = 16;  // instruction word width
  localparam int unsigned NREG = 8;   // general-purpose registers R0..R7

  // Flag register bit positions
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_NOT  = 4'h5,
    OP_INC  = 4'h6,
    OP_DEC  = 4'h7,
    OP_SHL  = 4'h8,
    OP_SHR  = 4'h9,
    OP_ROL  = 4'hA,
    OP_ROR  = 4'hB,
    OP_CLR  = 4'hC,
    OP_MUL  = 4'hD,
    OP_CTRL = 4'hE,
    OP_LDI  = 4'hF
  } opcode_e;

  // Control sub-op lives in the rd field of an OP_CTRL word
  typedef enum logic [2:0] {
    CTL_JMP  = 3'd0,
    CTL_JZ   = 3'd1,
    CTL_JC   = 3'd2,
    CTL_HALT = 3'd3,
    CTL_NOP4 = 3'd4,
    CTL_NOP5 = 3'd5,
    CTL_NOP6 = 3'd6,
    CTL_NOP7 = 3'd7
  } ctl_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU for the multicycle core.
// Ports:
//   i_op       opcode (ALU ops 0..B, D; anything else yields 0 and passes flags)
//   i_a, i_b   operands (i_a is rs1, or rd for INC/DEC)
//   i_shamt    shift / rotate amount
//   i_flags    current flag register, passed through where not updated
//   o_result_c result, o_flags_c next flag value
module mc_alu
  import mc_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic [3:0]    i_op,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [2:0]    i_shamt,
  input  logic [3:0]    i_flags,
  output logic [DW-1:0] o_result_c,
  output logic [3:0]    o_flags_c
);

  logic [DW:0]   w_sum;
  logic [DW:0]   w_diff;
  logic [DW-1:0] w_mul;
  logic [DW-1:0] w_res;
  logic          w_zn;

  // Extra MSB carries the carry-out / borrow
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_mul  = i_a * i_b;

  // Shift amount never exceeds 7 and DW >= 8, so shamt mod DW == shamt
  always_comb begin
    w_res     = '0;
    w_zn      = 1'b0;
    o_flags_c = i_flags;
    case (opcode_e'(i_op))
      OP_ADD: begin
        w_res             = w_sum[DW-1:0];
        w_zn              = 1'b1;
        o_flags_c[FLAG_C] = w_sum[DW];
        o_flags_c[FLAG_V] = (i_a[DW-1] == i_b[DW-1]) && (w_sum[DW-1] != i_a[DW-1]);
      end
      OP_SUB: begin
        w_res             = w_diff[DW-1:0];
        w_zn              = 1'b1;
        o_flags_c[FLAG_C] = w_diff[DW];
        o_flags_c[FLAG_V] = (i_a[DW-1] != i_b[DW-1]) && (w_diff[DW-1] != i_a[DW-1]);
      end
      OP_AND: begin w_res = i_a & i_b;          w_zn = 1'b1; end
      OP_OR:  begin w_res = i_a | i_b;          w_zn = 1'b1; end
      OP_XOR: begin w_res = i_a ^ i_b;          w_zn = 1'b1; end
      OP_NOT: begin w_res = ~i_a;               w_zn = 1'b1; end
      OP_INC: begin w_res = i_a + DW'(1);       w_zn = 1'b1; end
      OP_DEC: begin w_res = i_a - DW'(1);       w_zn = 1'b1; end
      OP_SHL: begin w_res = i_a << i_shamt;     w_zn = 1'b1; end
      OP_SHR: begin w_res = i_a >> i_shamt;     w_zn = 1'b1; end
      OP_ROL: begin
        w_res = (i_a << i_shamt) | (i_a >> (DW - 32'(i_shamt)));
        w_zn  = 1'b1;
      end
      OP_ROR: begin
        w_res = (i_a >> i_shamt) | (i_a << (DW - 32'(i_shamt)));
        w_zn  = 1'b1;
      end
      OP_MUL: begin w_res = w_mul;              w_zn = 1'b1; end
      default: begin
        w_res = '0;
        w_zn  = 1'b0;
      end
    endcase
    if (w_zn) begin
      o_flags_c[FLAG_Z] = (w_res == '0);
      o_flags_c[FLAG_N] = w_res[DW-1];
    end
  end

  assign o_result_c = w_res;

endmodule

// File: rtl/multicycle_core.sv
// Two-state-per-instruction multicycle core: FETCH waits for the
// instruction memory handshake, EXEC computes, writes back and retires.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   imem_req/addr      fetch request and address (== pc)
//   imem_valid/data    instruction return; only observed while in FETCH
//   flags              {V, N, C, Z}
//   halted             core sits in HALT until reset
//   retire             one-cycle pulse per completed instruction
module multicycle_core
  import mc_pkg::*;
#(
  parameter int unsigned DW  = 8,
  parameter int unsigned PCW = 8
) (
  input  logic           clk,
  input  logic           rst,
  output logic           imem_req,
  output logic [PCW-1:0] imem_addr,
  input  logic           imem_valid,
  input  logic [IW-1:0]  imem_data,
  output logic [3:0]     flags,
  output logic           halted,
  output logic           retire
);

  state_e                  r_state, w_state_nx;
  logic [PCW-1:0]          r_pc, w_pc_nx;
  logic [IW-1:0]           r_ir, w_ir_nx;
  logic [3:0]              r_flags, w_flags_nx;
  logic [NREG-1:0][DW-1:0] r_rf;
  logic                    r_req, w_req_nx;
  logic                    r_retire, w_retire_nx;
  logic                    r_halted, w_halted_nx;
  logic                    w_we;
  logic [DW-1:0]           w_wdata;

  opcode_e       w_op;
  ctl_e          w_ctl;
  logic [2:0]    w_rd, w_rs1, w_rs2, w_shamt;
  logic [8:0]    w_imm9;
  logic [DW-1:0] w_opa, w_opb, w_alu_res;
  logic [3:0]    w_alu_flags;

  // Instruction field decode
  assign w_op    = opcode_e'(r_ir[15:12]);
  assign w_ctl   = ctl_e'(r_ir[11:9]);
  assign w_rd    = r_ir[11:9];
  assign w_rs1   = r_ir[8:6];
  assign w_rs2   = r_ir[5:3];
  assign w_shamt = r_ir[2:0];
  assign w_imm9  = r_ir[8:0];

  // INC/DEC operate in place on rd
  assign w_opa = (w_op == OP_INC || w_op == OP_DEC) ? r_rf[w_rd] : r_rf[w_rs1];
  assign w_opb = r_rf[w_rs2];

  mc_alu #(.DW(DW)) u_alu (
    .i_op       (r_ir[15:12]),
    .i_a        (w_opa),
    .i_b        (w_opb),
    .i_shamt    (w_shamt),
    .i_flags    (r_flags),
    .o_result_c (w_alu_res),
    .o_flags_c  (w_alu_flags)
  );

  // State, architectural registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_FETCH;
      r_pc     <= '0;
      r_ir     <= '0;
      r_flags  <= '0;
      r_rf     <= '0;
      r_req    <= 1'b1;
      r_retire <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_pc     <= w_pc_nx;
      r_ir     <= w_ir_nx;
      r_flags  <= w_flags_nx;
      r_req    <= w_req_nx;
      r_retire <= w_retire_nx;
      r_halted <= w_halted_nx;
      if (w_we) begin
        r_rf[w_rd] <= w_wdata;
      end
    end
  end

  // Next-state, writeback and PC sequencing
  always_comb begin
    w_state_nx  = r_state;
    w_pc_nx     = r_pc;
    w_ir_nx     = r_ir;
    w_flags_nx  = r_flags;
    w_req_nx    = r_req;
    w_retire_nx = 1'b0;
    w_halted_nx = r_halted;
    w_we        = 1'b0;
    w_wdata     = '0;
    unique case (r_state)
      ST_FETCH: begin
        if (imem_valid) begin
          w_ir_nx    = imem_data;
          w_state_nx = ST_EXEC;
          w_req_nx   = 1'b0;
        end
      end
      ST_EXEC: begin
        w_retire_nx = 1'b1;
        w_state_nx  = ST_FETCH;
        w_req_nx    = 1'b1;
        w_pc_nx     = r_pc + PCW'(1);
        case (w_op)
          OP_CTRL: begin
            case (w_ctl)
              CTL_JMP: w_pc_nx = w_imm9[PCW-1:0];
              CTL_JZ:  if (r_flags[FLAG_Z]) w_pc_nx = w_imm9[PCW-1:0];
              CTL_JC:  if (r_flags[FLAG_C]) w_pc_nx = w_imm9[PCW-1:0];
              CTL_HALT: begin
                w_pc_nx     = r_pc;
                w_state_nx  = ST_HALT;
                w_req_nx    = 1'b0;
                w_halted_nx = 1'b1;
              end
              default: ;
            endcase
          end
          OP_LDI: begin
            w_we    = 1'b1;
            w_wdata = DW'(w_imm9);
          end
          OP_CLR: begin
            w_we    = 1'b1;
            w_wdata = '0;
          end
          default: begin
            w_we       = 1'b1;
            w_wdata    = w_alu_res;
            w_flags_nx = w_alu_flags;
          end
        endcase
      end
      ST_HALT: ;
      default: begin
        w_state_nx = ST_FETCH;
        w_req_nx   = 1'b1;
      end
    endcase
  end

  assign imem_req  = r_req;
  assign imem_addr = r_pc;
  assign flags     = r_flags;
  assign halted    = r_halted;
  assign retire    = r_retire;

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: an instruction-memory responder with
// configurable fetch latency feeds a reference ISA model; each fetched
// instruction pushes its expected post-retire state, popped on retire.
module tb_multicycle_core;

  localparam int unsigned DW  = 8;
  localparam int unsigned PCW = 8;

  localparam logic [3:0] K_ADD = 4'h0, K_SUB = 4'h1, K_AND = 4'h2, K_OR  = 4'h3;
  localparam logic [3:0] K_XOR = 4'h4, K_NOT = 4'h5, K_INC = 4'h6, K_DEC = 4'h7;
  localparam logic [3:0] K_SHL = 4'h8, K_SHR = 4'h9, K_ROL = 4'hA, K_ROR = 4'hB;
  localparam logic [3:0] K_CLR = 4'hC, K_MUL = 4'hD;

  typedef struct packed {
    logic [7:0]  pc;
    logic [3:0]  flags;
    logic [63:0] rf;
    logic        halted;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           imem_req;
  logic [PCW-1:0] imem_addr;
  logic           imem_valid;
  logic [15:0]    imem_data;
  logic [3:0]     flags;
  logic           halted;
  logic           retire;

  logic [15:0] mem [256];
  exp_t        sb_q [$];

  int   n_checks = 0;
  int   n_pass   = 0;
  int   retire_cnt = 0;
  int   wait_cnt = 0;
  int   fetch_delay = 0;
  logic [7:0] fetch_addr = '0;
  bit   stable_ok = 1'b1;

  // Reference model state
  int         m_pc;
  int         m_rf [8];
  logic [3:0] m_flags;
  logic       m_halted;

  logic [63:0] rf_now;

  multicycle_core #(.DW(DW), .PCW(PCW)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .flags      (flags),
    .halted     (halted),
    .retire     (retire)
  );

  initial forever #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] alu_i(input logic [3:0] op, input int rd, input int rs1,
                                        input int rs2, input int sh);
    return {op, 3'(rd), 3'(rs1), 3'(rs2), 3'(sh)};
  endfunction

  function automatic logic [15:0] ldi(input int rd, input int imm);
    return {4'hF, 3'(rd), 9'(imm)};
  endfunction

  function automatic logic [15:0] ctl(input int sub, input int imm);
    return {4'hE, 3'(sub), 9'(imm)};
  endfunction

  function automatic int sx(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  function automatic bit ovf(input int v);
    return (v > 127) || (v < -128);
  endfunction

  function automatic void model_init();
    m_pc     = 0;
    m_flags  = 4'h0;
    m_halted = 1'b0;
    for (int i = 0; i < 8; i++) m_rf[i] = 0;
  endfunction

  // Reference ISA semantics on plain integers
  function automatic void model_step(input logic [15:0] ins);
    int op, rd, rs1, rs2, s, imm, a, b, d, t, res, npc;
    bit wr, zn;
    op  = int'(ins[15:12]);
    rd  = int'(ins[11:9]);
    rs1 = int'(ins[8:6]);
    rs2 = int'(ins[5:3]);
    s   = int'(ins[2:0]);
    imm = int'(ins[8:0]);
    a   = m_rf[rs1];
    b   = m_rf[rs2];
    d   = m_rf[rd];
    res = 0; wr = 1; zn = 1;
    npc = (m_pc + 1) % 256;
    case (op)
      0: begin t = a + b; res = t % 256; m_flags[1] = (t > 255); m_flags[3] = ovf(sx(a) + sx(b)); end
      1: begin t = a - b; res = (t + 256) % 256; m_flags[1] = (a < b); m_flags[3] = ovf(sx(a) - sx(b)); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = 255 - a;
      6: res = (d + 1) % 256;
      7: res = (d + 255) % 256;
      8: res = (a << s) % 256;
      9: res = a >> s;
      10: res = ((a << s) | (a >> (8 - s))) % 256;
      11: res = ((a >> s) | (a << (8 - s))) % 256;
      12: begin res = 0; zn = 0; end
      13: res = (a * b) % 256;
      15: begin res = imm % 256; zn = 0; end
      default: begin
        wr = 0; zn = 0;
        case (rd)
          0: npc = imm % 256;
          1: if (m_flags[0]) npc = imm % 256;
          2: if (m_flags[1]) npc = imm % 256;
          3: begin npc = m_pc; m_halted = 1'b1; end
          default: ;
        endcase
      end
    endcase
    if (wr) m_rf[rd] = res;
    if (zn) begin
      m_flags[0] = (res == 0);
      m_flags[2] = (res >= 128);
    end
    m_pc = npc;
  endfunction

  function automatic exp_t model_snapshot();
    exp_t e;
    e.pc     = 8'(m_pc);
    e.flags  = m_flags;
    e.halted = m_halted;
    e.rf     = '0;
    for (int i = 0; i < 8; i++) e.rf[i*8 +: 8] = 8'(m_rf[i]);
    return e;
  endfunction

  // Retire monitor followed by instruction-memory responder
  initial begin : drv_mon
    exp_t e;
    imem_valid = 1'b0;
    imem_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (retire) begin
        retire_cnt++;
        if (sb_q.size() == 0) begin
          check_eq("sb_nonempty_at_retire", 64'(sb_q.size()), 64'(1));
        end else begin
          e = sb_q.pop_front();
          rf_now = dut.r_rf;
          check_eq("ret_pc",     64'(imem_addr), 64'(e.pc));
          check_eq("ret_flags",  64'(flags),     64'(e.flags));
          check_eq("ret_rf",     rf_now,         e.rf);
          check_eq("ret_halted", 64'(halted),    64'(e.halted));
        end
      end
      imem_valid = 1'b0;
      if (rst) begin
        wait_cnt  = 0;
        stable_ok = 1'b1;
      end else if (imem_req) begin
        if (wait_cnt == 0) fetch_addr = imem_addr;
        else if (imem_addr != fetch_addr) stable_ok = 1'b0;
        if (wait_cnt >= fetch_delay) begin
          if (fetch_delay > 0) check_eq("fetch_hold", 64'(stable_ok), 64'(1));
          imem_data  = mem[imem_addr];
          imem_valid = 1'b1;
          model_step(imem_data);
          sb_q.push_back(model_snapshot());
          wait_cnt  = 0;
          stable_ok = 1'b1;
        end else begin
          wait_cnt++;
        end
      end else if (wait_cnt > 0) begin
        stable_ok = 1'b0;
      end
    end
  end

  task automatic reset_begin();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = ctl(3, 0);
  endtask

  task automatic reset_end();
    repeat (2) @(negedge clk);
    sb_q.delete();
    model_init();
    retire_cnt = 0;
    rf_now = dut.r_rf;
    check_eq("rst_pc",     64'(imem_addr), 64'(0));
    check_eq("rst_flags",  64'(flags),     64'(0));
    check_eq("rst_rf",     rf_now,         64'(0));
    check_eq("rst_halted", 64'(halted),    64'(0));
    check_eq("rst_retire", 64'(retire),    64'(0));
    rst = 1'b0;
    @(negedge clk);
    check_eq("req_after_rst", 64'(imem_req), 64'(1));
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin @(negedge clk); n++; end
    check_eq("halt_reached", 64'(halted), 64'(1));
    check_eq("sb_drained", 64'(sb_q.size()), 64'(0));
  endtask

  task automatic wait_retires(input int target, input int budget);
    int n = 0;
    while (retire_cnt < target && n < budget) begin @(negedge clk); n++; end
    check_eq("retires_reached", 64'(retire_cnt), 64'(target));
  endtask

  task automatic load_prog2();
    mem[0] = ldi(0, 200);
    mem[1] = ldi(1, 100);
    mem[2] = alu_i(K_ADD, 2, 0, 1, 0);
    mem[3] = alu_i(K_SUB, 3, 1, 1, 0);
  endtask

  initial begin
    rst = 1'b1;
    model_init();

    // Basic add
    fetch_delay = 0;
    reset_begin();
    mem[0] = ldi(0, 10);
    mem[1] = ldi(1, 30);
    mem[2] = alu_i(K_ADD, 2, 0, 1, 0);
    reset_end();
    wait_halt(2000);
    rf_now = dut.r_rf;
    check_eq("t1_r2",      64'(rf_now[2*8 +: 8]), 64'(40));
    check_eq("t1_z",       64'(flags[0]), 64'(0));
    check_eq("t1_c",       64'(flags[1]), 64'(0));
    check_eq("t1_retires", 64'(retire_cnt), 64'(4));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("halt_hold", 64'({halted, imem_req}), 64'(2'b10));
    end

    // Carry on add, zero on sub; zero-wait then 5-cycle fetch latency
    for (int pass = 0; pass < 2; pass++) begin
      fetch_delay = (pass == 0) ? 0 : 5;
      reset_begin();
      load_prog2();
      reset_end();
      wait_halt(2000);
      rf_now = dut.r_rf;
      check_eq("t2_r2",      64'(rf_now[2*8 +: 8]), 64'(44));
      check_eq("t2_r3",      64'(rf_now[3*8 +: 8]), 64'(0));
      check_eq("t2_flags",   64'(flags), 64'(4'b0001));
      check_eq("t2_retires", 64'(retire_cnt), 64'(5));
    end

    // Conditional branch taken and not taken
    fetch_delay = 0;
    reset_begin();
    mem[0]  = ldi(0, 5);
    mem[1]  = alu_i(K_SUB, 1, 0, 0, 0);
    mem[2]  = ctl(1, 20);
    mem[20] = alu_i(K_ADD, 1, 0, 0, 0);
    mem[21] = ctl(1, 40);
    reset_end();
    wait_retires(3, 200);
    check_eq("jz_taken_addr", 64'(imem_addr), 64'(20));
    wait_retires(5, 200);
    check_eq("jz_fall_addr", 64'(imem_addr), 64'(22));
    wait_halt(200);
    check_eq("halt_pc_kept", 64'(imem_addr), 64'(22));

    // PC wrap after jump to last address
    reset_begin();
    mem[0]   = ctl(0, 255);
    mem[255] = ctl(4, 0);
    reset_end();
    wait_retires(1, 200);
    check_eq("jmp_addr", 64'(imem_addr), 64'(255));
    wait_retires(2, 200);
    check_eq("wrap_addr", 64'(imem_addr), 64'(0));

    // Full ALU sweep, ending on a taken JC
    fetch_delay = 1;
    reset_begin();
    mem[0]  = ldi(0, 9'h096);
    mem[1]  = ldi(1, 3);
    mem[2]  = alu_i(K_AND, 2, 0, 1, 0);
    mem[3]  = alu_i(K_OR,  3, 0, 1, 0);
    mem[4]  = alu_i(K_XOR, 4, 0, 1, 0);
    mem[5]  = alu_i(K_NOT, 5, 0, 0, 0);
    mem[6]  = alu_i(K_INC, 6, 0, 0, 0);
    mem[7]  = alu_i(K_DEC, 7, 0, 0, 0);
    mem[8]  = alu_i(K_SHL, 2, 0, 0, 3);
    mem[9]  = alu_i(K_SHR, 3, 0, 0, 2);
    mem[10] = alu_i(K_ROL, 4, 0, 0, 3);
    mem[11] = alu_i(K_ROR, 5, 0, 0, 5);
    mem[12] = alu_i(K_MUL, 6, 0, 1, 0);
    mem[13] = alu_i(K_CLR, 7, 0, 0, 0);
    mem[14] = ldi(3, 9'h1FF);
    mem[15] = alu_i(K_ADD, 4, 0, 0, 0);
    mem[16] = alu_i(K_SUB, 5, 1, 0, 0);
    mem[17] = alu_i(K_DEC, 7, 0, 0, 0);
    mem[18] = ctl(2, 50);
    reset_end();
    wait_halt(2000);
    rf_now = dut.r_rf;
    check_eq("alu_ldi_trunc", 64'(rf_now[3*8 +: 8]), 64'(255));
    check_eq("alu_add_wrap",  64'(rf_now[4*8 +: 8]), 64'(44));
    check_eq("alu_mul_low",   64'(rf_now[6*8 +: 8]), 64'(194));
    check_eq("alu_dec_wrap",  64'(rf_now[7*8 +: 8]), 64'(255));
    check_eq("alu_flags",     64'(flags), 64'(4'b0110));
    check_eq("jc_target",     64'(imem_addr), 64'(50));

    // Reset while a slow fetch is pending
    fetch_delay = 5;
    reset_begin();
    load_prog2();
    reset_end();
    wait_retires(3, 500);
    repeat (3) @(negedge clk);
    check_eq("mid_fetch_req", 64'(imem_req), 64'(1));
    reset_begin();
    load_prog2();
    fetch_delay = 0;
    reset_end();
    wait_halt(2000);
    rf_now = dut.r_rf;
    check_eq("rerun_r2", 64'(rf_now[2*8 +: 8]), 64'(44));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

endmodule
